// File: rtl/byte_bank_controller.sv
// Four-entry byte bank with debounced single-shot button writes and a display read pointer
// that either tracks the select switches or auto-scans the written entries.
module byte_bank_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned SCAN_CYCLES     = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic [7:0] data_in,
   input  logic [1:0] sel,
   input  logic       scan_en,
   output logic [3:0] wr_en,
   output logic [7:0] wr_data,
   output logic [1:0] rd_sel,
   output logic [7:0] rd_data,
   output logic [3:0] valid,
   output logic       busy
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned ScW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [ScW-1:0] ScLast = ScW'(SCAN_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StDebPress, StWrite, StWaitRel, StDebRel} state_e;

   state_e           state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [DbW-1:0]   cnt_q, cnt_d;
   logic [ScW-1:0]   scan_cnt_q, scan_cnt_d;
   logic [7:0]       bank_q [4];
   logic [7:0]       bank_d [4];
   logic [3:0]       valid_q, valid_d;
   logic [1:0]       rd_sel_q, rd_sel_d;
   logic [1:0]       next_sel;
   logic [1:0]       idx;
   logic             found;
   logic             btn_s;

   assign btn_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         sync_q     <= '0;
         cnt_q      <= '0;
         scan_cnt_q <= '0;
         bank_q     <= '{default: '0};
         valid_q    <= '0;
         rd_sel_q   <= '0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         scan_cnt_q <= scan_cnt_d;
         bank_q     <= bank_d;
         valid_q    <= valid_d;
         rd_sel_q   <= rd_sel_d;
      end
   end

   always_comb begin
      sync_d  = {sync_q[0], btn};
      state_d = state_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      valid_d = valid_q;
      wr_en   = 4'b0000;
      wr_data = 8'h00;
      case (state_q)
         StIdle: begin
            if (btn_s) begin
               state_d = StDebPress;
               cnt_d   = '0;
            end
         end
         StDebPress: begin
            if (!btn_s)              state_d = StIdle;
            else if (cnt_q == DbLast) state_d = StWrite;
            else                     cnt_d   = cnt_q + 1'b1;
         end
         StWrite: begin
            wr_en        = 4'b0001 << sel;
            wr_data      = data_in;
            bank_d[sel]  = data_in;
            valid_d[sel] = 1'b1;
            state_d      = StWaitRel;
         end
         StWaitRel: begin
            if (!btn_s) begin
               state_d = StDebRel;
               cnt_d   = '0;
            end
         end
         StDebRel: begin
            if (btn_s)               state_d = StWaitRel;
            else if (cnt_q == DbLast) state_d = StIdle;
            else                     cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Search rd_sel+1..rd_sel+4; the last step lands on rd_sel itself.
   always_comb begin
      next_sel = 2'd0;
      found    = 1'b0;
      idx      = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = rd_sel_q + 2'(i);
         if (!found && valid_q[idx]) begin
            next_sel = idx;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q;
      rd_sel_d   = rd_sel_q;
      if (!scan_en) begin
         rd_sel_d   = sel;
         scan_cnt_d = '0;
      end else if (scan_cnt_q == ScLast) begin
         scan_cnt_d = '0;
         rd_sel_d   = next_sel;
      end else begin
         scan_cnt_d = scan_cnt_q + 1'b1;
      end
   end

   assign rd_sel  = rd_sel_q;
   assign rd_data = bank_q[rd_sel_q];
   assign valid   = valid_q;
   assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_byte_bank_controller.sv
// Directed bench for byte_bank_controller with DEBOUNCE_CYCLES=4, SCAN_CYCLES=8.
module tb_byte_bank_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic [7:0] data_in;
   logic [1:0] sel;
   logic       scan_en;
   logic [3:0] wr_en;
   logic [7:0] wr_data;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;
   logic [3:0] valid;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int n_str;

   byte_bank_controller #(
      .DEBOUNCE_CYCLES(4),
      .SCAN_CYCLES    (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn),
      .data_in(data_in),
      .sel    (sel),
      .scan_en(scan_en),
      .wr_en  (wr_en),
      .wr_data(wr_data),
      .rd_sel (rd_sel),
      .rd_data(rd_data),
      .valid  (valid),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Returns just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [1:0] s, input logic [7:0] d);
      sel     = s;
      data_in = d;
      btn     = 1'b1;
      repeat (8) tick();
      // Now parked in WAIT_REL; scramble inputs to prove they are ignored.
      sel     = ~s;
      data_in = 8'hFF;
      btn     = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      reset   = 1'b1;
      btn     = 1'b1;
      data_in = 8'h00;
      sel     = 2'd0;
      scan_en = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_wr_en", wr_en, 4'b0000);
         check("rst_busy", busy, 1'b0);
      end
      check("rst_valid", valid, 4'b0000);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_sel", rd_sel, 2'd0);
      check("rst_wr_data", wr_data, 8'h00);
      reset = 1'b0;
      btn   = 1'b0;
      repeat (3) tick();

      // Clean press: edge k is the first tick below.
      sel     = 2'd2;
      data_in = 8'hA5;
      btn     = 1'b1;
      n_str   = 0;
      for (int m = 0; m < 20; m++) begin
         tick();
         if (wr_en != 4'b0000) n_str++;
         check("press_wr_en", wr_en, (m == 6) ? 4'b0100 : 4'b0000);
         check("press_wr_data", wr_data, (m == 6) ? 8'hA5 : 8'h00);
         check("press_busy", busy, (m >= 2));
         check("press_rd_data", rd_data, (m >= 7) ? 8'hA5 : 8'h00);
         check("press_valid", valid, (m >= 7) ? 4'b0100 : 4'b0000);
      end
      check("press_strobes", n_str, 1);

      btn = 1'b0;
      for (int m = 0; m < 8; m++) begin
         tick();
         check("rel_busy", busy, (m < 6));
      end

      // Bounce on press and on release.
      sel     = 2'd1;
      data_in = 8'h3C;
      for (int m = 0; m <= 22; m++) begin
         btn = !(m == 2 || m == 13 || m >= 15);
         tick();
         check("bnc_wr_en", wr_en, (m == 9) ? 4'b0010 : 4'b0000);
         check("bnc_busy", busy, ((m >= 2 && m <= 3) || (m >= 5 && m < 21)));
      end
      check("bnc_valid", valid, 4'b0110);

      press(2'd0, 8'h11);
      press(2'd1, 8'h22);
      press(2'd2, 8'h33);
      press(2'd3, 8'h44);
      check("all_valid", valid, 4'b1111);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         check("man_rd_sel", rd_sel, s);
         check("man_rd_data", rd_data, 8'h11 * (s + 1));
      end

      // Scan over valid=1010 starting from rd_sel=1.
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      check("scan_rst_valid", valid, 4'b0000);
      press(2'd1, 8'h5A);
      press(2'd3, 8'hC3);
      check("scan_valid", valid, 4'b1010);
      sel = 2'd1;
      tick();
      check("scan_start", rd_sel, 2'd1);
      scan_en = 1'b1;
      sel     = 2'd0;
      for (int t = 1; t <= 32; t++) begin
         tick();
         check("scan_rd_sel", rd_sel, (((t / 8) % 2) == 0) ? 2'd1 : 2'd3);
         check("scan_rd_data", rd_data, (((t / 8) % 2) == 0) ? 8'h5A : 8'hC3);
      end

      // Scan with nothing valid collapses to entry 0.
      scan_en = 1'b0;
      reset   = 1'b1;
      tick();
      reset = 1'b0;
      sel   = 2'd2;
      tick();
      check("empty_start", rd_sel, 2'd2);
      scan_en = 1'b1;
      repeat (7) tick();
      check("empty_hold", rd_sel, 2'd2);
      tick();
      check("empty_wrap", rd_sel, 2'd0);

      // Reset during DEB_PRESS at cnt=2.
      scan_en = 1'b0;
      sel     = 2'd0;
      data_in = 8'h77;
      btn     = 1'b1;
      repeat (5) tick();
      check("mid_busy_pre", busy, 1'b1);
      reset = 1'b1;
      tick();
      check("mid_busy_rst", busy, 1'b0);
      check("mid_wr_en_rst", wr_en, 4'b0000);
      reset = 1'b0;
      for (int m = 0; m < 8; m++) begin
         tick();
         check("mid_wr_en", wr_en, (m == 6) ? 4'b0001 : 4'b0000);
         check("mid_busy", busy, (m >= 2));
      end
      check("mid_valid", valid, 4'b0001);
      check("mid_rd_data", rd_data, 8'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
